clk_div_ctrl: RTL and testbench



---
 rtl/clk_div_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time controller for the system clock divider. It produces a registered,
// glitch-free divided clock from clk_in and starts and stops it cleanly.
// New half-period values arrive through a valid/ready port. While the divider
// is running, a new value is held as pending and is only applied at a falling
// boundary of clk_out, so no runt pulse can be produced.
//
// Parameters:
//   DIV_W        width of the half-period counter and of cfg_half
//   DEFAULT_HALF half-period loaded at reset (1 <= DEFAULT_HALF < 2^DIV_W)
//
// Ports:
//   clk_in     in   system clock; all logic runs on its rising edge
//   reset      in   asynchronous, active-high reset
//   run_en     in   1 = run the divided clock, 0 = stop at the next safe point
//   cfg_valid  in   a new half-period is offered
//   cfg_half   in   requested half-period in clk_in cycles
//   cfg_ready  out  controller can accept a configuration (no value pending)
//   cfg_err    out  one-cycle pulse: an offered half-period of 0 was rejected
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse in the cycle clk_out rises
//   active     out  1 whenever the controller is not idle
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int DIV_W        = 16,
    parameter int DEFAULT_HALF = 25
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] ZERO_C         = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_C          = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DEFAULT_HALF_C = DIV_W'(DEFAULT_HALF);

    state_t             state_r;
    state_t             state_s;
    logic [DIV_W-1:0]   cnt_r;
    logic [DIV_W-1:0]   cnt_s;
    logic [DIV_W-1:0]   cur_half_r;
    logic [DIV_W-1:0]   cur_half_s;
    logic [DIV_W-1:0]   pend_half_r;
    logic [DIV_W-1:0]   pend_half_s;
    logic               pend_r;
    logic               pend_s;
    logic               take_s;
    logic               accept_s;
    logic               reject_s;
    logic               last_s;

    // Handshake decode and end-of-phase detect. cfg_ready mirrors !pend_r,
    // so the transfer condition uses pend_r directly.
    always_comb begin
        take_s   = cfg_valid & ~pend_r;
        accept_s = take_s & (cfg_half != ZERO_C);
        reject_s = take_s & (cfg_half == ZERO_C);
        last_s   = (cnt_r == (cur_half_r - ONE_C));
    end

    // Next-state, counter and configuration decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        cur_half_s  = cur_half_r;
        pend_s      = pend_r;
        pend_half_s = pend_half_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = ZERO_C;
                // In idle a new value takes effect at once, so a start in the
                // same cycle already uses it for the first low phase.
                if (accept_s) begin
                    cur_half_s = cfg_half;
                end else begin
                    cur_half_s = cur_half_r;
                end
                if (run_en) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (accept_s) begin
                    pend_s      = 1'b1;
                    pend_half_s = cfg_half;
                end else begin
                    pend_s      = pend_r;
                end
                if (!run_en) begin
                    // clk_out is already low, so stopping here is glitch-free.
                    // Nothing may stay pending in idle: apply it now.
                    state_s = ST_IDLE;
                    cnt_s   = ZERO_C;
                    pend_s  = 1'b0;
                    if (pend_r) begin
                        cur_half_s = pend_half_r;
                    end else if (accept_s) begin
                        cur_half_s = cfg_half;
                    end else begin
                        cur_half_s = cur_half_r;
                    end
                end else if (last_s) begin
                    state_s = ST_HIGH;
                    cnt_s   = ZERO_C;
                end else begin
                    cnt_s   = cnt_r + ONE_C;
                end
            end
            ST_HIGH: begin
                if (accept_s) begin
                    pend_s      = 1'b1;
                    pend_half_s = cfg_half;
                end else begin
                    pend_s      = pend_r;
                end
                if (last_s) begin
                    // Falling boundary: the only point where the ratio may change.
                    // A value accepted in this very cycle waits for the next one.
                    cnt_s = ZERO_C;
                    if (pend_r) begin
                        cur_half_s = pend_half_r;
                        pend_s     = 1'b0;
                    end else begin
                        cur_half_s = cur_half_r;
                    end
                    if (!run_en) begin
                        state_s = ST_IDLE;
                        if (accept_s) begin
                            cur_half_s = cfg_half;
                            pend_s     = 1'b0;
                        end else begin
                            pend_s     = pend_s;
                        end
                    end else begin
                        state_s = ST_LOW;
                    end
                end else begin
                    cnt_s = cnt_r + ONE_C;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO_C;
                pend_s  = 1'b0;
            end
        endcase
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= ZERO_C;
            cur_half_r  <= DEFAULT_HALF_C;
            pend_half_r <= ZERO_C;
            pend_r      <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            active      <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            cur_half_r  <= cur_half_s;
            pend_half_r <= pend_half_s;
            pend_r      <= pend_s;
            clk_out     <= (state_s == ST_HIGH);
            tick        <= (state_r == ST_LOW) && (state_s == ST_HIGH);
            active      <= (state_s != ST_IDLE);
            cfg_ready   <= ~pend_s;
            cfg_err     <= reject_s;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        run_en;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        cfg_err;
    logic        clk_out;
    logic        tick;
    logic        active;

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl #(.DIV_W(16), .DEFAULT_HALF(25)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .active    (active)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        logic        run;
        logic        v;
        logic [15:0] half;
        logic        e_clk;
        logic        e_tick;
        logic        e_act;
        logic        e_rdy;
        logic        e_err;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Count falling edges until tick is seen (the tick sample included).
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=%0d required=tick within %0d", n, budget);
        end
    endtask

    // Count consecutive high samples of clk_out starting at the current one.
    task automatic count_high(output int n);
        n = 0;
        while (clk_out === 1'b1 && n < 200) begin
            n++;
            @(negedge clk_in);
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        run_en    = 1'b1;
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;

        // Reset held with run_en high: everything stays quiet.
        repeat (2) begin
            @(negedge clk_in);
            chk("rst_clk_out", clk_out, 0);
            chk("rst_active", active, 0);
            chk("rst_cfg_ready", cfg_ready, 1);
            chk("rst_tick", tick, 0);
            chk("rst_cfg_err", cfg_err, 0);
        end
        @(negedge clk_in);
        reset = 1'b0;

        // Default ratio: LOW entered on the first edge, tick 25 cycles later.
        wait_tick(200, n);
        chk("first_tick_latency", n, 26);
        chk("first_tick_clk_out", clk_out, 1);
        wait_tick(200, n);
        chk("default_period", n, 50);
        count_high(n);
        chk("default_high_len", n, 25);

        // Stop from LOW: idle on the next edge.
        run_en = 1'b0;
        @(negedge clk_in);
        chk("stop_low25_active", active, 0);
        chk("stop_low25_clk_out", clk_out, 0);

        // run v half | clk tick act rdy err
        vecs[0]  = '{1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        chk("idle_cfg_ready", cfg_ready, 1);
        for (int i = 0; i < 22; i++) begin
            run_en    = vecs[i].run;
            cfg_valid = vecs[i].v;
            cfg_half  = vecs[i].half;
            @(negedge clk_in);
            chk($sformatf("vec%0d_clk_out", i), clk_out, vecs[i].e_clk);
            chk($sformatf("vec%0d_tick", i), tick, vecs[i].e_tick);
            chk($sformatf("vec%0d_active", i), active, vecs[i].e_act);
            chk($sformatf("vec%0d_cfg_ready", i), cfg_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].e_err);
        end
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;

        // Half=4, stop requested on the 2nd HIGH cycle: HIGH still lasts 4.
        run_en = 1'b1;
        wait_tick(200, n);
        chk("half4_tick_latency", n, 5);
        @(negedge clk_in);
        chk("half4_high2", clk_out, 1);
        run_en = 1'b0;
        count_high(n);
        chk("stop_high_len", n + 1, 4);
        chk("stop_high_active", active, 0);
        chk("stop_high_clk_out", clk_out, 0);

        // Half=4, stop on a LOW cycle: idle on the next edge.
        run_en = 1'b1;
        @(negedge clk_in);
        chk("low_run_active", active, 1);
        run_en = 1'b0;
        @(negedge clk_in);
        chk("stop_low_active", active, 0);
        chk("stop_low_clk_out", clk_out, 0);

        // Stop request withdrawn before the falling boundary keeps running.
        run_en = 1'b1;
        wait_tick(200, n);
        run_en = 1'b0;
        @(negedge clk_in);
        run_en = 1'b1;
        count_high(n);
        chk("cancel_high_len", n, 3);
        chk("cancel_active", active, 1);

        // Reset while HIGH with a pending value: async clear, pending dropped.
        wait_tick(200, n);
        chk("cancel_next_tick", n, 4);
        cfg_valid = 1'b1;
        cfg_half  = 16'd2;
        @(negedge clk_in);
        cfg_valid = 1'b0;
        chk("pend_cfg_ready", cfg_ready, 0);
        chk("pend_clk_out", clk_out, 1);
        #5 reset = 1'b1;
        #1;
        chk("async_rst_clk_out", clk_out, 0);
        chk("async_rst_active", active, 0);
        chk("async_rst_cfg_ready", cfg_ready, 1);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        wait_tick(200, n);
        chk("post_rst_tick_latency", n, 26);
        wait_tick(200, n);
        chk("post_rst_period", n, 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
